uart_result_tx: RTL and testbench

- Downstream stage of systolic_top_uart_4parallel_q8_24.
- Captures the packed Q8.24 result matrix (3x3, 9 words x 32 bits) when the compute core signals completion.
- Serializes the result as 36 UART bytes (8N1) back to the host.
- Line rate matches the inbound loader: each bit is held BAUD_TICKS clock cycles.

---
 rtl/uart_result_tx.sv | 135 +++++++++++++
 tb/tb_uart_result_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_tx.sv
// Result serializer: captures the packed result matrix and sends it to the host
// as little-endian 8N1 UART bytes, word 0 first.
module uart_result_tx #(
  parameter int unsigned BAUD_TICKS = 10,
  parameter int unsigned NUM_WORDS  = 9,
  parameter int unsigned WORD_W     = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_WORDS*WORD_W-1:0]   result_data_packed,
  input  logic                          result_valid_in,
  output logic                          tx_out,
  output logic                          busy_out,
  output logic                          done_out,
  output logic [5:0]                    byte_idx_out
);

  localparam int unsigned TotalW = NUM_WORDS * WORD_W;
  localparam int unsigned NumBytes = TotalW / 8;
  localparam int unsigned BaudW = $clog2(BAUD_TICKS);
  localparam int unsigned IdxW = $clog2(TotalW);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_TICKS - 1);
  localparam logic [5:0] LastByte = 6'(NumBytes - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

  state_e              state_q, state_d;
  logic [BaudW-1:0]    baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [5:0]          byte_q, byte_d;
  logic [TotalW-1:0]   shadow_q, shadow_d;
  logic                tx_q, tx_d;
  logic                baud_end;
  logic [IdxW-1:0]     bit_pos;

  assign baud_end = (baud_q == BaudLast);

  // Next-state logic; the line level is computed for the upcoming cycle so tx_out is a pure flop.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shadow_d = shadow_q;
    tx_d     = 1'b1;
    bit_pos  = '0;

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        bit_d  = '0;
        byte_d = '0;
        if (result_valid_in) begin
          shadow_d = result_data_packed;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q < LastByte) begin
            byte_d  = byte_q + 6'd1;
            state_d = StStart;
          end else begin
            byte_d  = '0;
            state_d = StDone;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StDone: begin
        baud_d  = '0;
        bit_d   = '0;
        byte_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Byte b bit i lives at shadow[8b+i]; {byte, bit} is exactly that offset.
    bit_pos = IdxW'({byte_d, bit_d});
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shadow_d[bit_pos];
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset drives the line high immediately.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
    end
  end

  assign tx_out       = tx_q;
  assign busy_out     = (state_q != StIdle) && (state_q != StDone);
  assign done_out     = (state_q == StDone);
  assign byte_idx_out = byte_q;

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx: a host-side 8N1 sampler decodes the line and compares
// against bytes derived from the submitted words.
module tb_uart_result_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [287:0] data;
  logic         valid;
  logic         tx, busy, done;
  logic [5:0]   idx;

  logic [31:0]  data6;
  logic         valid6;
  logic         tx6, busy6, done6;
  logic [5:0]   idx6;

  int checks = 0;
  int errors = 0;

  uart_result_tx dut (
    .clk_in            (clk),
    .rst_in            (rst_n),
    .result_data_packed(data),
    .result_valid_in   (valid),
    .tx_out            (tx),
    .busy_out          (busy),
    .done_out          (done),
    .byte_idx_out      (idx)
  );

  uart_result_tx #(
    .BAUD_TICKS(4),
    .NUM_WORDS (1),
    .WORD_W    (32)
  ) dut6 (
    .clk_in            (clk),
    .rst_in            (rst_n),
    .result_data_packed(data6),
    .result_valid_in   (valid6),
    .tx_out            (tx6),
    .busy_out          (busy6),
    .done_out          (done6),
    .byte_idx_out      (idx6)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input bit sel);
    return sel ? tx6 : tx;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy6 : busy;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? done6 : done;
  endfunction
  function automatic logic [5:0] get_idx(input bit sel);
    return sel ? idx6 : idx;
  endfunction

  // Host view: word w = d[32w +: 32], sent least-significant byte first.
  function automatic logic [7:0] exp_byte(input logic [287:0] d, input int b);
    logic [287:0] t;
    logic [31:0]  w;
    t = d >> (32 * (b / 4));
    w = t[31:0];
    w = w >> (8 * (b % 4));
    return w[7:0];
  endfunction

  task automatic set_in(input bit sel, input logic [287:0] d, input logic v);
    if (sel) begin
      data6  = d[31:0];
      valid6 = v;
    end else begin
      data  = d;
      valid = v;
    end
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) valid6 = v;
    else valid = v;
  endtask

  // Present one valid pulse; returns just after the capture edge.
  task automatic capture(input bit sel, input logic [287:0] d);
    @(negedge clk);
    set_in(sel, d, 1'b1);
    @(posedge clk);
  endtask

  // Follow one frame from the cycle after capture. inj_k: cycle of a stray valid pulse,
  // rst_k: cycle to assert reset, retrig: pulse valid in DONE and the following cycle.
  task automatic run_frame(input bit sel, input logic [287:0] d, input int bt, input int nbytes,
                           input int inj_k, input int rst_k, input bit retrig);
    int total;
    int done_seen;
    int pos;
    int b;
    bit aborted;
    logic [7:0] sh;
    total = nbytes * 10 * bt;
    done_seen = 0;
    aborted = 1'b0;
    sh = '0;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (k == 0) begin
        set_valid(sel, 1'b0);
        check_eq("first_tx_low", 64'(get_tx(sel)), 64'd0);
        check_eq("busy_after_capture", 64'(get_busy(sel)), 64'd1);
      end
      if (k == inj_k) set_in(sel, ~d, 1'b1);
      if (k == inj_k + 1) set_valid(sel, 1'b0);
      if (get_done(sel)) done_seen++;
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_tx", 64'(get_tx(sel)), 64'd1);
        check_eq("rst_busy", 64'(get_busy(sel)), 64'd0);
        check_eq("rst_idx", 64'(get_idx(sel)), 64'd0);
        aborted = 1'b1;
        break;
      end
      if (k % bt == bt / 2) begin
        pos = (k / bt) % 10;
        b = k / (10 * bt);
        if (pos == 0) begin
          check_eq($sformatf("start_bit%0d", b), 64'(get_tx(sel)), 64'd0);
          check_eq($sformatf("idx%0d", b), 64'(get_idx(sel)), 64'(b));
          sh = '0;
        end else if (pos <= 8) begin
          sh[pos-1] = get_tx(sel);
        end else begin
          check_eq($sformatf("stop_bit%0d", b), 64'(get_tx(sel)), 64'd1);
          check_eq($sformatf("byte%0d", b), 64'(sh), 64'(exp_byte(d, b)));
        end
      end
    end
    check_eq("no_early_done", 64'(done_seen), 64'd0);
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        if (get_done(sel)) done_seen++;
      end
      check_eq("no_done_after_reset", 64'(done_seen), 64'd0);
      rst_n = 1'b1;
      return;
    end
    @(negedge clk);
    check_eq("done_pulse", 64'(get_done(sel)), 64'd1);
    check_eq("done_busy", 64'(get_busy(sel)), 64'd0);
    check_eq("done_idx", 64'(get_idx(sel)), 64'd0);
    check_eq("done_tx", 64'(get_tx(sel)), 64'd1);
    if (retrig) set_in(sel, d, 1'b1);
    @(negedge clk);
    check_eq("done_one_cycle", 64'(get_done(sel)), 64'd0);
    if (retrig) begin
      check_eq("done_pulse_ignored_busy", 64'(get_busy(sel)), 64'd0);
      check_eq("done_pulse_ignored_tx", 64'(get_tx(sel)), 64'd1);
      @(posedge clk);
    end else begin
      done_seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (get_done(sel)) done_seen++;
      end
      check_eq("stays_idle", 64'(get_busy(sel)), 64'd0);
      check_eq("single_done", 64'(done_seen), 64'd0);
    end
  endtask

  initial begin
    logic [287:0] d;
    data = '0;
    valid = 1'b0;
    data6 = '0;
    valid6 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_tx", 64'(tx), 64'd1);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_idx", 64'(idx), 64'd0);
    check_eq("reset_tx6", 64'(tx6), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.0 in word 0, zeros elsewhere
    d = '0;
    d[31:0] = 32'h0100_0000;
    capture(1'b0, d);
    run_frame(1'b0, d, 10, 36, -1, -1, 1'b0);

    // Distinct pattern per word
    for (int k = 0; k < 9; k++) d[32*k +: 32] = 32'hA5A5_A5A5 ^ 32'(k);
    capture(1'b0, d);
    run_frame(1'b0, d, 10, 36, -1, -1, 1'b0);

    // Stray valid mid-transfer is dropped
    for (int k = 0; k < 9; k++) d[32*k +: 32] = $urandom;
    capture(1'b0, d);
    run_frame(1'b0, d, 10, 36, 500, -1, 1'b0);

    // Reset in the middle of a data bit, then a clean frame
    for (int k = 0; k < 9; k++) d[32*k +: 32] = $urandom;
    capture(1'b0, d);
    run_frame(1'b0, d, 10, 36, -1, 1234, 1'b0);
    @(negedge clk);
    check_eq("post_rst_tx", 64'(tx), 64'd1);
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 9; k++) d[32*k +: 32] = $urandom;
    capture(1'b0, d);
    run_frame(1'b0, d, 10, 36, -1, -1, 1'b1);
    // Retrigger right after DONE was accepted
    run_frame(1'b0, d, 10, 36, -1, -1, 1'b0);

    // Small configuration: 4 cycles/bit, one word
    d = '0;
    d[31:0] = 32'h80FF_0001;
    capture(1'b1, d);
    run_frame(1'b1, d, 4, 4, -1, -1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      d = '0;
      d[31:0] = $urandom;
      capture(1'b1, d);
      run_frame(1'b1, d, 4, 4, -1, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
